// File: rtl/synth_voice_controller.sv
// synth_voice_controller: buttons to per-channel enable/waveform/pitch, with a tempo-driven demo sequencer.
// SYNTH_SEQ_WRITE_EN makes the demo memory writable; otherwise it is a constant ROM.
module synth_voice_controller #(
  parameter int NUM_CHANNELS = 4,
  parameter int PITCH_W = 12,
  parameter int SEQ_DEPTH = 16,
  parameter int STEP_CYCLES = 6_000_000,
  parameter int GAP_CYCLES = 600_000,
  parameter int BASE_PITCH = 212
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_CHANNELS+1:0]           buttons_db,
  input  logic [$clog2(SEQ_DEPTH)-1:0]      seq_len,
  input  logic                              seq_wr_en,
  input  logic [$clog2(SEQ_DEPTH)-1:0]      seq_wr_addr,
  input  logic [PITCH_W:0]                  seq_wr_data,
  output logic [NUM_CHANNELS-1:0]           channel_ena,
  output logic [2*NUM_CHANNELS-1:0]         waveforms,
  output logic [PITCH_W*NUM_CHANNELS-1:0]   pitches,
  output logic                              demo_active,
  output logic [$clog2(SEQ_DEPTH)-1:0]      seq_ptr,
  output logic                              step_pulse
);
  localparam int AW = $clog2(SEQ_DEPTH);
  localparam int CW = $clog2(STEP_CYCLES);
  typedef enum logic [1:0] {PLAY, DEMO, DEMO_GAP} state_t;
  state_t state_q, state_d;
  logic [NUM_CHANNELS+1:0] prev_q, rise;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [1:0] wave_q, wave_d;
  logic [NUM_CHANNELS-1:0] ena_q, ena_d;
  logic [PITCH_W*NUM_CHANNELS-1:0] pitch_q, pitch_d;
  logic pulse_q, pulse_d, demo_q, exit_demo, playing;
  logic [PITCH_W:0] mem [SEQ_DEPTH];
  logic [PITCH_W:0] entry;
`ifdef SYNTH_SEQ_WRITE_EN
  for (genvar i = 0; i < SEQ_DEPTH; i++) begin : g_mem
    logic [PITCH_W:0] e_q = {1'b1, PITCH_W'(BASE_PITCH + 8 * i)};
    always_ff @(posedge clk) if (seq_wr_en && seq_wr_addr == AW'(i)) e_q <= seq_wr_data;
    assign mem[i] = e_q;
  end
`else
  for (genvar i = 0; i < SEQ_DEPTH; i++) begin : g_mem
    assign mem[i] = {1'b1, PITCH_W'(BASE_PITCH + 8 * i)};
  end
  logic unused_wr;
  assign unused_wr = ^{seq_wr_en, seq_wr_addr, seq_wr_data};
`endif
  assign rise = buttons_db & ~prev_q;
  assign exit_demo = |rise[NUM_CHANNELS+1:1];
  assign entry = mem[ptr_d];
  assign playing = state_d == DEMO && entry[PITCH_W];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    pulse_d = 1'b0;
    wave_d = wave_q + {1'b0, rise[0]};
    if (state_q == PLAY) begin
      if (rise[1]) begin
        state_d = DEMO;
        cnt_d = '0;
        ptr_d = '0;
      end
    end else if (exit_demo) state_d = PLAY;
    else if (state_q == DEMO) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(STEP_CYCLES - GAP_CYCLES - 1)) state_d = DEMO_GAP;
    end else if (cnt_q == CW'(STEP_CYCLES - 1)) begin
      state_d = DEMO;
      cnt_d = '0;
      ptr_d = (ptr_q == seq_len) ? '0 : ptr_q + 1'b1;
      pulse_d = 1'b1;
    end else cnt_d = cnt_q + 1'b1;
  end
  // Outputs are registered from the next state, so rests and gaps leave pitches at their last values.
  always_comb begin
    ena_d = state_d == PLAY ? buttons_db[NUM_CHANNELS+1:2] : playing ? '1 : '0;
    pitch_d = pitch_q;
    for (int k = 0; k < NUM_CHANNELS; k++)
      pitch_d[PITCH_W*k +: PITCH_W] = state_d == PLAY ? PITCH_W'(BASE_PITCH >> k) :
                                      playing ? entry[PITCH_W-1:0] >> k : pitch_q[PITCH_W*k +: PITCH_W];
  end
  always_ff @(posedge clk) begin
    prev_q <= buttons_db;
    if (!rst_n) begin
      state_q <= PLAY;
      cnt_q <= '0;
      ptr_q <= '0;
      wave_q <= '0;
      ena_q <= '0;
      pitch_q <= '0;
      pulse_q <= 1'b0;
      demo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      wave_q <= wave_d;
      ena_q <= ena_d;
      pitch_q <= pitch_d;
      pulse_q <= pulse_d;
      demo_q <= state_d != PLAY;
    end
  end
  assign channel_ena = ena_q;
  assign waveforms = {NUM_CHANNELS{wave_q}};
  assign pitches = pitch_q;
  assign demo_active = demo_q;
  assign seq_ptr = ptr_q;
  assign step_pulse = pulse_q;
endmodule

// File: tb/tb_synth_voice_controller.sv
// tb_synth_voice_controller: randomized and directed checks against a step/phase reference model.
module tb_synth_voice_controller;
  localparam int NC = 4, PW = 12, DEPTH = 16, STEP = 10, GAP = 3, BASE = 212;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NC+1:0] btn = '0;
  logic [3:0] seq_len = 4'd2, wr_addr = '0;
  logic wr_en = 1'b0;
  logic [PW:0] wr_data = '0;
  logic [NC-1:0] channel_ena;
  logic [2*NC-1:0] waveforms;
  logic [PW*NC-1:0] pitches;
  logic demo_active, step_pulse;
  logic [3:0] seq_ptr;
  logic [65:0] dut_vec;
  always #5 clk = ~clk;
  synth_voice_controller #(.NUM_CHANNELS(NC), .PITCH_W(PW), .SEQ_DEPTH(DEPTH), .STEP_CYCLES(STEP),
    .GAP_CYCLES(GAP), .BASE_PITCH(BASE)) dut (.clk(clk), .rst_n(rst_n), .buttons_db(btn), .seq_len(seq_len),
    .seq_wr_en(wr_en), .seq_wr_addr(wr_addr), .seq_wr_data(wr_data), .channel_ena(channel_ena),
    .waveforms(waveforms), .pitches(pitches), .demo_active(demo_active), .seq_ptr(seq_ptr), .step_pulse(step_pulse));
  assign dut_vec = {channel_ena, waveforms, pitches, demo_active, seq_ptr, step_pulse};
  // Reference model: demo progress is tracked as elapsed cycles since entry; step = el / STEP, phase = el % STEP.
  logic [PW:0] m_mem [DEPTH];
  logic [NC+1:0] m_prev = '0;
  logic m_demo = 0, m_pulse = 0;
  int m_el = 0;
  logic [3:0] m_ptr = '0;
  logic [1:0] m_wave = '0;
  logic [NC-1:0] m_ena = '0;
  logic [PW-1:0] m_pitch [NC];
  int n_vec = 0, n_err = 0;
  function automatic logic [65:0] exp_vec();
    logic [PW*NC-1:0] p;
    for (int k = 0; k < NC; k++) p[PW*k +: PW] = m_pitch[k];
    return {m_ena, {NC{m_wave}}, p, m_demo, m_ptr, m_pulse};
  endfunction
  task automatic model_edge();
    logic [NC+1:0] r;
    r = btn & ~m_prev;
    if (!rst_n) begin
      m_demo = 0; m_el = 0; m_ptr = '0; m_wave = '0; m_ena = '0; m_pulse = 0;
      for (int k = 0; k < NC; k++) m_pitch[k] = '0;
    end else begin
      m_wave = m_wave + 2'(r[0]);
      m_pulse = 0;
      if (!m_demo) begin
        if (r[1]) begin m_demo = 1; m_el = 0; m_ptr = '0; end
      end else if (r[NC+1:1] != '0) m_demo = 0;
      else begin
        m_el++;
        if (m_el % STEP == 0) begin
          m_ptr = (m_ptr == seq_len) ? 4'd0 : m_ptr + 4'd1;
          m_pulse = 1;
        end
      end
      if (!m_demo) begin
        m_ena = btn[NC+1:2];
        for (int k = 0; k < NC; k++) m_pitch[k] = PW'(BASE >> k);
      end else if (m_el % STEP < STEP - GAP && m_mem[m_ptr][PW]) begin
        m_ena = '1;
        for (int k = 0; k < NC; k++) m_pitch[k] = m_mem[m_ptr][PW-1:0] >> k;
      end else m_ena = '0;
    end
    m_prev = btn;
`ifdef SYNTH_SEQ_WRITE_EN
    if (wr_en) m_mem[wr_addr] = wr_data;
`endif
  endtask
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    btn = 6'b000100;
    rst_n = 0;
    repeat (2) tick();
    n_vec++;
    if (dut_vec !== 66'd0) begin n_err++; $display("FAIL reset_values: got %h want 0", dut_vec); end
    rst_n = 1;
    tick();
    n_vec++;
    if (channel_ena !== 4'b0001 || pitches !== {12'd26, 12'd53, 12'd106, 12'd212} || waveforms !== 8'd0) begin
      n_err++; $display("FAIL reset_release: got ena %b pitches %h wave %h", channel_ena, pitches, waveforms);
    end
  endtask
  task automatic test_waveform();
    for (int i = 1; i <= 4; i++) begin
      btn[0] = 1;
      btn[NC+1:2] = 4'($urandom);
      tick();
      n_vec++;
      if (waveforms !== {NC{2'(i)}} || dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL waveform_%0d: got %h want %h", i, dut_vec, exp_vec());
      end
      btn[0] = 0;
      tick();
      n_vec++;
      if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL waveform_hold_%0d: got %h want %h", i, dut_vec, exp_vec()); end
    end
  endtask
  task automatic test_demo();
    int hi, pulses;
    hi = 0; pulses = 0;
    btn = 6'b000100;
    seq_len = 4'd2;
    tick();
    btn[1] = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      btn[1] = 0;
      if (i < 10 && channel_ena === 4'hf) hi++;
      if (step_pulse === 1'b1) pulses++;
      n_vec++;
      if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL demo_cyc_%0d: got %h want %h", i, dut_vec, exp_vec()); end
    end
    n_vec++;
    if (hi !== 7 || pulses !== 3 || seq_ptr !== 4'd0) begin
      n_err++; $display("FAIL demo_shape: got hi %0d pulses %0d ptr %0d want 7 3 0", hi, pulses, seq_ptr);
    end
  endtask
  task automatic test_key_exit();
    repeat (4) tick();
    btn[3] = 1;
    tick();
    n_vec++;
    if (demo_active !== 1'b0 || dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL key_exit: got %h want %h", dut_vec, exp_vec());
    end
    btn[3] = 0;
    btn[1] = 1;
    tick();
    btn[1] = 0;
    n_vec++;
    if (seq_ptr !== 4'd0 || demo_active !== 1'b1 || dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL demo_restart: got %h want %h", dut_vec, exp_vec());
    end
  endtask
`ifdef SYNTH_SEQ_WRITE_EN
  task automatic test_rest();
    btn[1] = 1;
    tick();
    btn[1] = 0;
    wr_en = 1; wr_addr = 4'd1; wr_data = {1'b0, 12'($urandom)};
    tick();
    wr_en = 0;
    btn[1] = 1;
    for (int i = 0; i < 25; i++) begin
      tick();
      btn[1] = 0;
      n_vec++;
      if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL rest_cyc_%0d: got %h want %h", i, dut_vec, exp_vec()); end
      if (i >= 10 && i < 20) begin
        n_vec++;
        if (channel_ena !== 4'd0 || pitches !== {12'd26, 12'd53, 12'd106, 12'd212}) begin
          n_err++; $display("FAIL rest_hold_%0d: got ena %b pitches %h", i, channel_ena, pitches);
        end
      end
    end
  endtask
`endif
  task automatic test_reset_mid();
    logic [PW-1:0] p2;
    p2 = PW'(BASE + 16);
`ifdef SYNTH_SEQ_WRITE_EN
    p2 = 12'($urandom);
    wr_en = 1; wr_addr = 4'd2; wr_data = {1'b1, p2};
`endif
    seq_len = 4'd2;
    tick();
    wr_en = 0;
    if (!m_demo) begin btn[1] = 1; tick(); btn[1] = 0; end
    for (int i = 0; i < 20 && m_el % STEP != 8; i++) tick();
    rst_n = 0;
    tick();
    n_vec++;
    if (dut_vec !== 66'd0 || dut_vec !== exp_vec()) begin n_err++; $display("FAIL reset_mid: got %h want 0", dut_vec); end
    rst_n = 1;
    tick();
    btn[1] = 1;
    for (int i = 0; i <= 20; i++) begin
      tick();
      btn[1] = 0;
      n_vec++;
      if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL after_reset_cyc_%0d: got %h want %h", i, dut_vec, exp_vec()); end
    end
    n_vec++;
    if (seq_ptr !== 4'd2 || pitches[PW-1:0] !== p2 || channel_ena !== 4'hf) begin
      n_err++; $display("FAIL mem_survives_reset: got ptr %0d pitch %0d want 2 %0d", seq_ptr, pitches[PW-1:0], p2);
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < NC + 2; b++) if ($urandom_range(0, 23) == 0) btn[b] = ~btn[b];
      if ($urandom_range(0, 31) == 0) seq_len = 4'($urandom);
      rst_n = $urandom_range(0, 149) != 0;
      wr_en = $urandom_range(0, 7) == 0;
      wr_addr = 4'($urandom);
      wr_data = 13'($urandom);
      tick();
      n_vec++;
      if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL random_%0d: got %h want %h", i, dut_vec, exp_vec()); end
    end
    wr_en = 0;
  endtask
  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = {1'b1, PW'(BASE + 8 * i)};
    for (int k = 0; k < NC; k++) m_pitch[k] = '0;
    test_reset();
    test_waveform();
    test_demo();
    test_key_exit();
`ifdef SYNTH_SEQ_WRITE_EN
    test_rest();
`endif
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
